// File: rtl/btn_event_if.sv
// Event handshake between btn_event and its consumers (UART TX formatter, LED logic).
//   evt_valid_o : event available in the producer's holding register
//   evt_code_o  : 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   evt_ready_i : consumer accepts; transfer when valid & ready on a rising edge
// Signal suffixes are from the producer's point of view.
interface btn_event_if;
    logic       evt_valid_o;
    logic [1:0] evt_code_o;
    logic       evt_ready_i;

    modport master (output evt_valid_o, output evt_code_o, input evt_ready_i);
    modport slave  (input evt_valid_o, input evt_code_o, output evt_ready_i);
endinterface

// File: rtl/btn_event.sv
// Button event generator: turns a debounced button level into PRESS / RELEASE / LONG /
// REPEAT events, presented through a one-deep holding register on a valid/ready handshake.
// Ports:
//   clk_i      system clock
//   arst_n_i   asynchronous reset, active low
//   deb_i      debounced button level, synchronous to clk_i
//   evt        event handshake (master side): valid, 2-bit code, ready
//   held_o     registered pressed state (high in PRESSED or HELD)
//   evt_ovf_o  sticky flag: an event was dropped because the holding register was full
//   ovf_clr_i  synchronous clear of evt_ovf_o (a drop in the same cycle wins)
module btn_event #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned LONG_PRESS_MS = 500,
    parameter int unsigned REPEAT_MS     = 100,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         deb_i,
    btn_event_if.master  evt,
    output logic         held_o,
    output logic         evt_ovf_o,
    input  logic         ovf_clr_i
);

    localparam int unsigned LONG_CYC = CLK_FREQ / 1000 * LONG_PRESS_MS;
    localparam int unsigned REP_CYC  = CLK_FREQ / 1000 * REPEAT_MS;
    localparam int unsigned MAX_CYC  = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    // Guarded so a disabled REPEAT does not underflow the terminal count.
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REP_CYC > 0) ? REP_CYC - 1 : 0);
    localparam bit               REP_EN    = (REPEAT_MS > 0);

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             valid_q, valid_d;
    logic [1:0]       code_q, code_d;
    logic             ovf_q, ovf_d;

    logic             pressed;
    logic             gen;
    logic [1:0]       gen_code;

    assign pressed = deb_i ^ ACTIVE_LOW;

    // Event FSM: one transition per clock, release takes priority over terminal counts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gen      = 1'b0;
        gen_code = EVT_PRESS;
        unique case (state_q)
            StIdle: begin
                if (pressed) begin
                    state_d  = StPressed;
                    cnt_d    = '0;
                    gen      = 1'b1;
                    gen_code = EVT_PRESS;
                end
            end
            StPressed: begin
                if (!pressed) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    gen      = 1'b1;
                    gen_code = EVT_RELEASE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d  = StHeld;
                    cnt_d    = '0;
                    gen      = 1'b1;
                    gen_code = EVT_LONG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHeld: begin
                if (!pressed) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    gen      = 1'b1;
                    gen_code = EVT_RELEASE;
                end else if (REP_EN && (cnt_q == REP_LAST)) begin
                    cnt_d    = '0;
                    gen      = 1'b1;
                    gen_code = EVT_REPEAT;
                end else if (REP_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // held_o tracks the next state so it changes on the same edge the FSM leaves/enters IDLE.
    assign held_d = (state_d != StIdle);

    // One-deep holding register. A new event loads if the slot is empty or being drained
    // this cycle; otherwise it is dropped and the overflow flag is set.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (gen) begin
            if (!valid_q || evt.evt_ready_i) begin
                valid_d = 1'b1;
                code_d  = gen_code;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt.evt_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= EVT_PRESS;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt.evt_valid_o = valid_q;
    assign evt.evt_code_o  = code_q;
    assign held_o          = held_q;
    assign evt_ovf_o       = ovf_q;

endmodule

// File: doc/btn_event.md
Name: btn_event

Overview:
- Sits directly downstream of the button debouncer and consumes its debounced level output.
- Turns the level into discrete button events: PRESS, RELEASE, LONG (held past a threshold) and REPEAT (periodic while held).
- Presents each event as a 2-bit code on a valid/ready handshake for the UART TX formatter and LED logic, with a one-deep holding register and a sticky overflow flag.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- LONG_PRESS_MS, 500, hold time in ms before LONG fires; integer, must be >= 1.
- REPEAT_MS, 100, REPEAT period in ms after LONG; integer, 0 disables REPEAT.
- ACTIVE_LOW, 1, 1 means deb_i=0 is "pressed" (DE0-Nano KEY polarity); 0 means deb_i=1 is "pressed".

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous reset, active low.
- deb_i  in  1  debounced button level from the debouncer; already synchronous to clk_i.
- evt_valid_o  out  1  event available in the holding register.
- evt_code_o  out  2  event code: 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
- evt_ready_i  in  1  consumer accepts the event; transfer occurs when valid and ready are both high on a rising edge.
- held_o  out  1  registered pressed state, 1 while in PRESSED or HELD.
- evt_ovf_o  out  1  sticky flag: an event was dropped.
- ovf_clr_i  in  1  synchronous clear of evt_ovf_o.

Behaviour:
- Derived values:
  - LONG_CYC = CLK_FREQ/1000*LONG_PRESS_MS.
  - REP_CYC = CLK_FREQ/1000*REPEAT_MS.
  - Counter width = $clog2(max(LONG_CYC, REP_CYC)+1).
  - No wrap is possible; the counter resets on every terminal count.
- Input decode: pressed = deb_i ^ ACTIVE_LOW.
- Asynchronous reset, while arst_n_i=0:
  - state=IDLE, cnt=0.
  - evt_valid_o=0, evt_code_o=00, held_o=0, evt_ovf_o=0.
- On reset release, the FSM evaluates deb_i normally. If the button is already pressed, PRESS is emitted on the first edge; this is intended, the same as a fresh press.
- FSM states and transitions (one transition per clock):
  - IDLE, pressed=1: go to PRESSED, cnt=0, generate PRESS.
  - PRESSED, pressed=0: go to IDLE, generate RELEASE; no LONG is emitted.
  - PRESSED, pressed=1, cnt==LONG_CYC-1: go to HELD, cnt=0, generate LONG.
  - PRESSED, pressed=1, otherwise: cnt+1.
  - HELD, pressed=0: go to IDLE, generate RELEASE.
  - HELD, pressed=1, REPEAT_MS>0 and cnt==REP_CYC-1: stay in HELD, cnt=0, generate REPEAT.
  - HELD, pressed=1, otherwise: cnt+1. If REPEAT_MS=0, cnt stays at 0.
  - Release has priority over a LONG or REPEAT terminal count in the same cycle: only RELEASE is generated.
- Timing:
  - held_o goes high/low on the same edge the FSM leaves/enters IDLE.
  - evt_valid_o rises on the same edge the event is generated, i.e. 1 clock after deb_i changes at the sampling edge.
  - LONG is generated exactly LONG_CYC clocks after PRESS.
  - Each REPEAT is generated exactly REP_CYC clocks after the preceding LONG or REPEAT.
- Holding register:
  - evt_valid_o and evt_code_o stay stable until accepted.
  - On acceptance with no new event, evt_valid_o clears on that edge.
  - New event while the register is empty, or in the same cycle as acceptance: loaded, evt_valid_o=1. Back-to-back throughput is 1 event/clock.
  - New event while evt_valid_o=1 and evt_ready_i=0: the new event is dropped, the held event is kept, and evt_ovf_o is set on that edge.
- evt_ovf_o:
  - Clears only on reset or ovf_clr_i=1.
  - If a drop and ovf_clr_i happen in the same cycle, set wins.
- Reset mid-operation: all state is lost immediately and asynchronously. No RELEASE is emitted for a press that was interrupted by reset.
- evt_ready_i is ignored when evt_valid_o=0.

Test Plan (CLK_FREQ=1_000_000, LONG_PRESS_MS=2 -> 2000 cycles, REPEAT_MS=1 -> 1000 cycles, ACTIVE_LOW=1, evt_ready_i=1 unless stated):
- Reset then deb_i=1 for 50 cycles -> evt_valid_o=0, held_o=0, evt_ovf_o=0 throughout.
- deb_i 1->0 for 500 cycles, then back to 1:
  - PRESS valid 1 clock after the fall; held_o=1.
  - RELEASE valid 1 clock after the rise; held_o=0; no LONG.
- deb_i=0 held 3500 cycles:
  - PRESS at t, LONG at t+2000, REPEAT at t+3000.
  - RELEASE follows the rise; exactly 4 events seen.
- evt_ready_i=0, press then release 10 cycles later:
  - evt_code_o stays 00 (PRESS) with valid=1.
  - RELEASE is dropped; evt_ovf_o=1.
  - Pulse ovf_clr_i -> evt_ovf_o=0. Raise ready -> PRESS accepted, valid=0.
- Release on the exact cycle cnt==1999 -> only RELEASE, no LONG.
- Assert arst_n_i=0 at 1000 cycles into a press:
  - All outputs 0 immediately.
  - Release reset with deb_i=0 -> PRESS on the first edge, and LONG 2000 cycles later.
- Instance with REPEAT_MS=0, hold 5000 cycles -> only PRESS and LONG, then RELEASE after the rise.
